instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 179 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches 32-bit instructions, decodes them and
// drives memory handshakes, register-file/PSR strobes and the program counter.
module instr_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [4:0]  psr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [3:0]  rf_raddr,
    output logic [3:0]  rf_waddr,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [3:0]  alu_op,
    output logic        psr_we,
    output logic [11:0] pc,
    output logic [31:0] ir,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_WRITE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_STR = 4'h2;
    localparam logic [3:0] OP_BRA = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_ROT = 4'h6;
    localparam logic [3:0] OP_SHF = 4'h7;
    localparam logic [3:0] OP_HLT = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;

    state_t      state;
    state_t      state_next;
    logic [11:0] pc_next;
    logic [31:0] ir_next;
    logic [11:0] pc_inc;

    // psr bit order: [0] carry, [1] parity, [2] even, [3] negative, [4] zero
    function automatic logic branch_taken(input logic [3:0] cond, input logic [4:0] flags);
        logic taken;
        case (cond)
            4'h0:    taken = 1'b1;
            4'h1:    taken = flags[1];
            4'h2:    taken = flags[2];
            4'h3:    taken = flags[0];
            4'h4:    taken = flags[3];
            4'h5:    taken = flags[4];
            4'h6:    taken = ~flags[0];
            4'h7:    taken = ~flags[3];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign pc_inc   = pc + 12'd1;
    assign alu_op   = ir[31:28];
    assign rf_raddr = ir[15:12];
    assign rf_waddr = ir[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // Memory outputs are decoded from state so an async reset drops mem_req at once.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        rf_we      = 1'b0;
        rf_wsel    = 1'b0;
        psr_we     = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                case (ir[31:28])
                    OP_NOP: begin
                        pc_next    = pc_inc;
                        state_next = S_FETCH;
                    end
                    OP_LD:  state_next = S_READ;
                    OP_STR: state_next = S_WRITE;
                    OP_BRA: begin
                        pc_next    = branch_taken(ir[27:24], psr) ? ir[11:0] : pc_inc;
                        state_next = S_FETCH;
                    end
                    OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: state_next = S_EXEC;
                    OP_HLT: state_next = S_HALT;
                    default: begin
                        illegal    = 1'b1;
                        pc_next    = pc_inc;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_READ: begin
                mem_req  = 1'b1;
                mem_addr = ir[23:12];
                if (mem_ack) begin
                    rf_we      = 1'b1;
                    psr_we     = 1'b1;
                    pc_next    = pc_inc;
                    state_next = S_FETCH;
                end
            end

            S_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ir[11:0];
                if (mem_ack) begin
                    pc_next    = pc_inc;
                    state_next = S_FETCH;
                end
            end

            S_EXEC: begin
                psr_we     = 1'b1;
                rf_wsel    = 1'b1;
                rf_we      = (ir[31:28] != OP_CMP);
                pc_next    = pc_inc;
                state_next = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed spec scenarios plus random
// instruction streams compared against a program-counter/strobe reference model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [4:0]  psr;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  rf_raddr;
    logic [3:0]  rf_waddr;
    logic        rf_we;
    logic        rf_wsel;
    logic [3:0]  alu_op;
    logic        psr_we;
    logic [11:0] pc;
    logic [31:0] ir;
    logic        halted;
    logic        illegal;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] m_pc;

    instr_sequencer #(.RESET_PC(12'h100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .psr(psr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_op(alu_op), .psr_we(psr_we),
        .pc(pc), .ir(ir), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference: next pc after one instruction, from the opcode/condition tables.
    function automatic logic [11:0] model_next_pc(input logic [31:0] instr,
                                                  input logic [11:0] cur,
                                                  input logic [4:0] f);
        int op;
        int cond;
        int seq;
        bit taken;
        op   = int'(instr[31:28]);
        cond = int'(instr[27:24]);
        seq  = (int'(cur) + 1) % 4096;
        if (op == 8) return cur;
        if (op != 3) return seq[11:0];
        case (cond)
            0:       taken = 1'b1;
            1:       taken = f[1];   // parity
            2:       taken = f[2];   // even
            3:       taken = f[0];   // carry
            4:       taken = f[3];   // negative
            5:       taken = f[4];   // zero
            6:       taken = !f[0];
            7:       taken = !f[3];
            default: taken = 1'b0;
        endcase
        return taken ? instr[11:0] : seq[11:0];
    endfunction

    task automatic run_instr(input logic [31:0] instr, input int flat, input int dlat,
                             input logic [4:0] f);
        logic [3:0]  op;
        logic [11:0] exp_pc;
        logic [11:0] daddr;
        int          waited;
        bit          is_exec;
        op      = instr[31:28];
        is_exec = (op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h9});
        waited  = 0;
        while (!mem_req && waited < 20) begin
            step();
            waited++;
        end
        chk("fetch_req", mem_req, 1);
        chk("fetch_addr", mem_addr, m_pc);
        chk("fetch_we", mem_we, 0);
        for (int k = 0; k < flat; k++) begin
            step();
            chk("fetch_hold_req", mem_req, 1);
            chk("fetch_hold_addr", mem_addr, m_pc);
        end
        mem_rdata = instr;
        psr       = f;
        mem_ack   = 1'b1;
        #1;
        chk("fetch_strobes", {rf_we, psr_we, illegal}, 0);
        step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom();
        chk("decode_ir", ir, instr);
        chk("alu_op", alu_op, op);
        chk("rf_raddr", rf_raddr, instr[15:12]);
        chk("rf_waddr", rf_waddr, instr[3:0]);
        chk("decode_req", mem_req, 0);
        chk("illegal", illegal, (op >= 4'hA));
        chk("decode_strobes", {rf_we, psr_we}, 0);
        exp_pc = model_next_pc(instr, m_pc, f);
        if (op == 4'h1 || op == 4'h2) begin
            daddr = (op == 4'h1) ? instr[23:12] : instr[11:0];
            step();
            for (int k = 0; k < dlat; k++) begin
                chk("data_req", mem_req, 1);
                chk("data_we", mem_we, (op == 4'h2));
                chk("data_addr", mem_addr, daddr);
                chk("data_wait_strobes", {rf_we, psr_we}, 0);
                step();
            end
            chk("data_addr_ack", mem_addr, daddr);
            mem_ack = 1'b1;
            #1;
            chk("data_rf_we", rf_we, (op == 4'h1));
            chk("data_psr_we", psr_we, (op == 4'h1));
            if (op == 4'h1) chk("data_rf_wsel", rf_wsel, 0);
            step();
            mem_ack = 1'b0;
            chk("post_data_strobes", {rf_we, psr_we}, 0);
        end else if (is_exec) begin
            step();
            chk("exec_psr_we", psr_we, 1);
            chk("exec_rf_we", rf_we, (op != 4'h9));
            if (op != 4'h9) chk("exec_rf_wsel", rf_wsel, 1);
            chk("exec_req", mem_req, 0);
            step();
            chk("post_exec_strobes", {rf_we, psr_we}, 0);
        end else if (op == 4'h8) begin
            step();
            chk("halted", halted, 1);
            chk("halt_req", mem_req, 0);
        end else begin
            step();
            chk("illegal_one_cycle", illegal, 0);
        end
        chk("pc", pc, exp_pc);
        m_pc = exp_pc;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [3:0]  rop;
        rst_n     = 1'b0;
        start     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        psr       = '0;
        repeat (2) step();
        chk("rst_pc", pc, 12'h100);
        chk("rst_ir", ir, 0);
        chk("rst_outs", {mem_req, mem_we, rf_we, psr_we, halted, illegal}, 0);

        rst_n   = 1'b1;
        mem_ack = 1'b1;
        repeat (3) begin
            step();
            chk("idle_no_req", mem_req, 0);
        end
        mem_ack = 1'b0;
        chk("idle_ir", ir, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        m_pc  = 12'h100;

        run_instr(32'h0000_0000, 0, 0, 5'b00000);
        run_instr(32'h1005_0003, 0, 3, 5'b00000);
        run_instr(32'h3500_0200, 1, 0, 5'b10000);
        run_instr(32'h3500_0200, 0, 0, 5'b00000);
        run_instr(32'h3600_0200, 0, 0, 5'b00001);
        run_instr(32'h9001_2002, 0, 0, 5'b00000);
        run_instr(32'h5001_2002, 2, 0, 5'b00000);
        run_instr(32'h2000_7ABC, 1, 2, 5'b00000);
        run_instr(32'hC000_0000, 0, 0, 5'b00000);

        start = 1'b1;
        repeat (60) begin
            rnd = $urandom();
            rop = rnd[31:28];
            if (rop == 4'h8) rnd[31:28] = 4'h0;
            run_instr(rnd, $urandom_range(0, 3), $urandom_range(0, 3),
                      5'($urandom_range(0, 31)));
        end

        run_instr(32'h3000_0FFF, 0, 0, 5'b00000);
        run_instr(32'h0000_0000, 0, 0, 5'b00000);
        chk("pc_wrap", pc, 12'h000);

        run_instr(32'h8000_0000, 0, 0, 5'b00000);
        repeat (8) begin
            start   = 1'b1;
            mem_ack = 1'($urandom_range(0, 1));
            step();
            chk("halt_stay", halted, 1);
            chk("halt_quiet", {mem_req, rf_we, psr_we, illegal}, 0);
            chk("halt_pc", pc, 12'h000);
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_pc_after_halt", pc, 12'h100);
        chk("rst_halted", halted, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_rst", mem_req, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("fetch_before_abort", mem_req, 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req_drops", mem_req, 0);
        step();
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h8000_0000;
        step();
        mem_ack = 1'b0;
        chk("late_ack_ignored_req", mem_req, 0);
        chk("late_ack_ignored_ir", ir, 0);
        step();
        chk("still_idle", mem_req, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        m_pc  = 12'h100;
        run_instr(32'h0000_0000, 0, 0, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
